// File: rtl/fetch_pkg.sv
// Fetch-stage shared types: queue entry bundle and width helpers.
// Ports: none (package).
package fetch_pkg;
  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/inst_queue.sv
// Instruction queue: sync FIFO of {pc, inst} with flush.
// Ports: clk/rst_n, push/push_data, pop, flush, head, empty, count.
module inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = wr_ptr == rd_ptr;
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: owns PC, issues imem requests, queues words for decode.
// Ports: imem req/resp channel, redirect, inst head to decode, fetch_fault.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH        = 2,
  parameter int              MAX_INFLIGHT = 4,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = cnt_w(MAX_INFLIGHT);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [IW-1:0]   inflight;
  logic [IW-1:0]   discard;
  logic            fault;

  logic [CW-1:0]   count;
  logic            empty;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  logic [31:0]     occ;
  logic            req_fire;
  logic            resp_keep;
  logic            q_pop;
  logic [IW-1:0]   req_inc;
  logic [IW-1:0]   resp_dec;

  // Slots already claimed: queued words plus live (non-stale) requests.
  assign occ = 32'(count) + 32'(inflight) - 32'(discard);

  // No requests while held in reset.
  assign imem_req_valid = rst_n && !redirect_valid && !fault
                        && (occ < 32'(DEPTH))
                        && (32'(inflight) < 32'(MAX_INFLIGHT));

  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign resp_keep     = imem_resp_valid && (discard == '0)
                       && !redirect_valid;
  assign q_pop         = inst_ready && !redirect_valid;
  assign req_inc       = IW'(req_fire);
  assign resp_dec      = IW'(imem_resp_valid);

  assign push_entry.pc   = resp_pc;
  assign push_entry.inst = imem_resp_data;

  assign inst_valid  = !empty;
  assign inst        = empty ? '0 : head.inst;
  assign inst_pc     = empty ? '0 : head.pc;
  assign fetch_fault = fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      fault    <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      resp_pc  <= redirect_pc;
      // Everything still outstanding after this edge is stale.
      inflight <= inflight - resp_dec;
      discard  <= inflight - resp_dec;
      fault    <= redirect_pc[1:0] != 2'b00;
    end else begin
      if (req_fire)
        pc <= pc + XLEN'(INST_BYTES);
      if (resp_keep)
        resp_pc <= resp_pc + XLEN'(INST_BYTES);
      if (imem_resp_valid && (discard != '0))
        discard <= discard - IW'(1);
      inflight <= inflight + req_inc - resp_dec;
    end
  end

  inst_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (resp_keep),
    .push_data(push_entry),
    .pop      (q_pop),
    .flush    (redirect_valid),
    .head     (head),
    .empty    (empty),
    .count    (count)
  );
endmodule
